prbs_checker: RTL and testbench

//  - Downstream consumer of the 8-bit LFSR pattern generator. Self-synchronises to the

---
 rtl/prbs_checker.sv | 168 ++++++++++++++++
 tb/tb_prbs_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS-8 receive checker: self-synchronises to an LFSR word stream and reports lock and errors.
// Optional macro BIT_ERR_COUNT_EN adds a saturating bit-error counter port.
module prbs_checker #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
`ifdef BIT_ERR_COUNT_EN
    output logic [CNT_W-1:0] bit_err_count,
`endif
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[3] ^ cur[1]};
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [RUN_W-1:0] match_q, match_d;
    logic [RUN_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] err_count_d;
    logic             locked_d, err_pulse_d, lock_lost_d;
    logic             mismatch_c;
    logic             locked_err_c;
    logic [RUN_W-1:0] match_inc_c;
    logic [RUN_W-1:0] miss_inc_c;

    assign mismatch_c   = (in_data != pred_q);
    assign locked_err_c = in_valid && (state_q == LOCKED) && mismatch_c;
    assign match_inc_c  = match_q + RUN_W'(1);
    assign miss_inc_c   = miss_q + RUN_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_data != 8'h00) state_d = VERIFY;
                end
                VERIFY: begin
                    if (!mismatch_c) begin
                        if (match_inc_c == RUN_W'(LOCK_CNT)) state_d = LOCKED;
                    end else if (in_data == 8'h00) begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (mismatch_c && (miss_inc_c == RUN_W'(UNLOCK_CNT))) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Next values of the predictor, run counters and registered outputs
    always_comb begin
        pred_d      = pred_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_count_d = err_count;
        err_pulse_d = 1'b0;
        lock_lost_d = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_data != 8'h00) begin
                        pred_d  = lfsr_next(in_data);
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    if (!mismatch_c) begin
                        pred_d  = lfsr_next(pred_q);
                        match_d = match_inc_c;
                        if (match_inc_c == RUN_W'(LOCK_CNT)) miss_d = '0;
                    end else begin
                        pred_d  = lfsr_next(in_data);
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running reference: one corrupted word costs exactly one error
                    pred_d = lfsr_next(pred_q);
                    if (mismatch_c) begin
                        err_pulse_d = 1'b1;
                        miss_d      = miss_inc_c;
                        if (err_count != {CNT_W{1'b1}}) err_count_d = err_count + CNT_W'(1);
                        if (miss_inc_c == RUN_W'(UNLOCK_CNT)) lock_lost_d = 1'b1;
                    end else begin
                        miss_d = '0;
                    end
                end
                default: pred_d = pred_q;
            endcase
        end
        if (clear) err_count_d = '0;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_q    <= 8'h00;
            match_q   <= '0;
            miss_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            pred_q    <= pred_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked    <= locked_d;
            err_pulse <= err_pulse_d;
            lock_lost <= lock_lost_d;
            err_count <= err_count_d;
        end
    end

`ifdef BIT_ERR_COUNT_EN
    logic [3:0]       bit_pop_c;
    logic [CNT_W:0]   bit_sum_c;
    logic [CNT_W-1:0] bit_err_count_d;

    assign bit_pop_c = 4'($countones(in_data ^ pred_q));
    assign bit_sum_c = {1'b0, bit_err_count} + (CNT_W + 1)'(bit_pop_c);

    // Saturating accumulation of flipped bits on errored words
    always_comb begin
        bit_err_count_d = bit_err_count;
        if (locked_err_c) begin
            bit_err_count_d = bit_sum_c[CNT_W] ? {CNT_W{1'b1}} : bit_sum_c[CNT_W-1:0];
        end
        if (clear) bit_err_count_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bit_err_count <= '0;
        else        bit_err_count <= bit_err_count_d;
    end
`else
    logic unused_c;
    assign unused_c = locked_err_c;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus randomized stream vs. a spec model.
module tb_prbs_checker;

    localparam int unsigned CW      = 8;
    localparam int unsigned LOCK_N  = 4;
    localparam int unsigned UNLOCK_N = 3;
    localparam int          CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          clear = 1'b0;
    logic          locked, err_pulse, lock_lost;
    logic [CW-1:0] err_count;
`ifdef BIT_ERR_COUNT_EN
    logic [CW-1:0] bit_err_count;
`endif

    prbs_checker #(.LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLOCK_N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
`ifdef BIT_ERR_COUNT_EN
        .bit_err_count(bit_err_count),
`endif
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Spec model: mode 0 hunting, 1 verifying a seed, 2 locked
    int         m_mode = 0, m_run = 0, m_miss = 0, m_cnt = 0, m_bits = 0;
    logic [7:0] m_pred = 8'h00;
    bit         m_pulse = 1'b0, m_lost = 1'b0;
    logic [7:0] g;

    function automatic logic [7:0] nxt(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[3] ^ c[1]};
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_bits = 0;
        m_pred = 8'h00; m_pulse = 1'b0; m_lost = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit c);
        m_pulse = 1'b0;
        m_lost  = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 8'h00) begin m_mode = 1; m_pred = nxt(d); m_run = 0; end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_run++;
                    m_pred = nxt(m_pred);
                    if (m_run == LOCK_N) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_run = 0;
                    m_pred = nxt(d);
                    if (d == 8'h00) m_mode = 0;
                end
            end else begin
                if (d != m_pred) begin
                    m_pulse = 1'b1;
                    m_cnt  = sat(m_cnt + 1);
                    m_bits = sat(m_bits + $countones(d ^ m_pred));
                    m_miss++;
                    if (m_miss == UNLOCK_N) begin m_mode = 0; m_lost = 1'b1; end
                end else begin
                    m_miss = 0;
                end
                m_pred = nxt(m_pred);
            end
        end
        if (c) begin m_cnt = 0; m_bits = 0; end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("locked", 32'(locked), 32'(m_mode == 2));
            chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
            chk("lock_lost", 32'(lock_lost), 32'(m_lost));
            chk("err_count", 32'(err_count), 32'(m_cnt));
`ifdef BIT_ERR_COUNT_EN
            chk("bit_err_count", 32'(bit_err_count), 32'(m_bits));
`endif
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit c);
        in_valid = v; in_data = d; clear = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic word(input logic [7:0] mask);
        cyc(1'b1, g ^ mask, 1'b0);
        g = nxt(g);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        model_reset();
        #20 reset = 1'b1;
        check_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);

        // Clean stream from FF locks after the fifth word
        g = 8'hFF;
        for (int i = 0; i < 4; i++) word(8'h00);
        chk("lock_after4", 32'(locked), 32'd0);
        chk("gen_fifth_word", 32'(g), 32'hF3);
        word(8'h00);
        chk("lock_after5", 32'(locked), 32'd1);

        // Single corruption: one error, lock held
        word(8'h01);
        chk("single_err_pulse", 32'(err_pulse), 32'd1);
        chk("single_err_count", 32'(err_count), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        word(8'h00);
        chk("single_next_ok", 32'(err_pulse), 32'd0);

        // Three consecutive corruptions drop lock on the third
        word(8'h10); word(8'h10);
        chk("burst_still_locked", 32'(locked), 32'd1);
        word(8'h10);
        chk("burst_lock_lost", 32'(lock_lost), 32'd1);
        chk("burst_locked", 32'(locked), 32'd0);
        chk("burst_err_count", 32'(err_count), 32'd4);
        for (int i = 0; i < 4; i++) word(8'h00);
        chk("relock_after4", 32'(locked), 32'd0);
        word(8'h00);
        chk("relock_after5", 32'(locked), 32'd1);

        // Zero words never seed; gapped clean stream still locks
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 1'b0);
        chk("zero_hunt", 32'(locked), 32'd0);
        g = 8'h5A;
        for (int i = 0; i < 5; i++) begin word(8'h00); cyc(1'b0, 8'hAA, 1'b0); end
        chk("gapped_lock", 32'(locked), 32'd1);

        // Saturation with interleaved good words, then clear colliding with an error
        for (int i = 0; i < CMAX + 6; i++) begin word(8'h01); word(8'h00); end
        chk("sat_err_count", 32'(err_count), 32'(CMAX));
        chk("sat_locked", 32'(locked), 32'd1);
        cyc(1'b1, g ^ 8'h01, 1'b1); g = nxt(g);
        chk("clear_wins", 32'(err_count), 32'd0);
        chk("clear_pulse", 32'(err_pulse), 32'd1);
        word(8'h00);

`ifdef BIT_ERR_COUNT_EN
        cyc(1'b0, 8'h00, 1'b1);
        word(8'hFF);
        chk("bits_plus8", 32'(bit_err_count), 32'd8);
        word(8'h01);
        chk("bits_plus1", 32'(bit_err_count), 32'd9);
        word(8'h00);
`endif

        // Randomized stream: clean words, corruptions, bursts, gaps, zeros, reseeds, clears
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60)       word(8'h00);
            else if (r < 68)  word(8'($urandom_range(1, 255)));
            else if (r < 72)  begin
                for (int k = 0; k < 3; k++) word(8'($urandom_range(1, 255)));
            end
            else if (r < 82)  cyc(1'b0, 8'($urandom), 1'b0);
            else if (r < 85)  cyc(1'b1, 8'h00, 1'b0);
            else if (r < 88)  g = 8'($urandom_range(1, 255));
            else if (r < 91)  begin
                cyc(1'b1, g ^ 8'($urandom_range(0, 1)), 1'b1); g = nxt(g);
            end
            else if (r < 92)  do_reset();
            else              word(8'h00);
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
